// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, digit type and converter state enum
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] ADJ_OFFSET = 4'd3;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when digit >= 5
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  // d <= 9 on entry, so d + 3 never exceeds 12 and needs no carry
  assign q = (d >= ADJ_THRESH) ? d + ADJ_OFFSET : d;

endmodule

// File: rtl/bin_2_bcd_seq.sv
// rtl/bin_2_bcd_seq.sv - sequential binary-to-BCD converter, one bit per clock
module bin_2_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       thous,
  output logic [3:0]       huns,
  output logic [3:0]       tens,
  output logic [3:0]       units
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = DIGITS * BCD_W;

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   adj;
  logic [SCR_W-1:0]   next_scratch;
  logic [SCR_W-1:0]   result;
  logic [CNT_W-1:0]   cnt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scratch[g*BCD_W +: BCD_W]),
      .q (adj[g*BCD_W +: BCD_W])
    );
  end

  // adjusted scratch shifted left, pulling in the next binary MSB
  assign next_scratch = {adj[SCR_W-2:0], shreg[BIN_W-1]};

  assign thous = result[4*BCD_W-1 -: BCD_W];
  assign huns  = result[3*BCD_W-1 -: BCD_W];
  assign tens  = result[2*BCD_W-1 -: BCD_W];
  assign units = result[1*BCD_W-1 -: BCD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      scratch <= '0;
      result  <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= next_scratch;
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result <= next_scratch;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_2_bcd_seq.sv
// tb/tb_bin_2_bcd_seq.sv - scoreboard testbench for bin_2_bcd_seq
module tb_bin_2_bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] bin_in = '0;
  logic       busy, done;
  logic [3:0] thous, huns, tens, units;

  bin_2_bcd_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .thous  (thous),
    .huns   (huns),
    .tens   (tens),
    .units  (units)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    int          acc;
  } sb_t;

  sb_t q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  n_acc = 0;
  int  last_acc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // protocol model: a start seen while idle is an accepted conversion
  always @(posedge clk) begin
    if (rst_n && start && !busy) begin
      q.push_back('{ref_bcd(int'(bin_in)), cyc + 1});
      n_acc++;
      last_acc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (busy && done) check("busy_and_done", 1, 0);
    if (done) begin
      if (q.size() == 0) begin
        check("spurious_done", int'(done), 0);
      end else begin
        sb_t e;
        e = q.pop_front();
        check("digits", int'({thous, huns, tens, units}), int'(e.exp));
        check("latency", cyc - e.acc, 10);
        check("digit_range",
              int'(thous > 9 || huns > 9 || tens > 9 || units > 9), 0);
      end
    end
  end

  task automatic wait_accept();
    int a = n_acc;
    int k = 0;
    while (n_acc == a && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_acc == a) check("accept_timeout", n_acc - a, 1);
  endtask

  task automatic convert(input int v);
    bin_in = 10'(v);
    start  = 1'b1;
    wait_accept();
    start  = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    check("drain", q.size(), 0);
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_digits", int'({thous, huns, tens, units}), 0);
    repeat (5) @(posedge clk);
    #1;

    convert(0);    wait_drain();
    convert(999);  wait_drain();
    convert(1023); wait_drain();
    convert(512);  wait_drain();

    // back-to-back with start held high: one acceptance every 11 cycles
    start = 1'b1;
    t0 = 0;
    for (int v = 0; v < 1024; v++) begin
      bin_in = 10'(v);
      wait_accept();
      if (v == 0) t0 = last_acc;
    end
    start = 1'b0;
    check("accept_period", last_acc - t0, 1023 * 11);
    wait_drain();

    // retriggers and bin_in changes during a conversion are ignored
    convert(345);
    repeat (2) @(posedge clk);
    #1 bin_in = 10'd777; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_drain();
    check("ignore_restart", int'({thous, huns, tens, units}), int'(ref_bcd(345)));

    // reset mid-conversion aborts without a done pulse
    convert(600);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_digits", int'({thous, huns, tens, units}), 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_result", int'({thous, huns, tens, units}), 0);
    convert(42); wait_drain();

    // outputs hold while idle
    convert(88); wait_drain();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("hold_digits", int'({thous, huns, tens, units}), int'(ref_bcd(88)));
    check("hold_done", int'(done), 0);
    check("hold_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
